axi_sram_slv: RTL
=================

Name: axi_sram_slv

Overview:
AXI3 responder that terminates the CPU's external AXI master port (ar/r/aw/w/b channels) with an on-chip word-addressed SRAM. It is the memory end of the bus for simulation and FPGA bring-up. Independent read and write FSMs each allow one outstanding transaction and support FIXED and INCR bursts up to 16 beats, with OKAY/SLVERR/DECERR responses.

Parameters:
ADDR_BITS, 12, log2 of SRAM depth in 32-bit words (16 KiB default)
BASE_ADDR, 32'h1c00_0000, byte base address; decoded on addr[31:ADDR_BITS+2]

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  4  beats-1
arsize  in  3  must be 3'b010
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (rejected)
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1
arready  out  1
rid  out  4
rdata  out  32
rresp  out  2
rlast  out  1
rvalid  out  1
rready  in  1
awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2  as AR
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1
awready  out  1
wid  in  4
wdata  in  32
wstrb  in  4
wlast  in  1
wvalid  in  1
wready  out  1
bid  out  4
bresp  out  2
bvalid  out  1
bready  in  1

Behaviour:
- Reset (async, resetn=0): all outputs 0; FSMs to *_RST. First clk edge after deassertion: go to IDLE, arready=awready=1 (registered). SRAM contents not reset.
- Read FSM R_RST -> R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, capture id/addr/len/burst/size, beat=0, arready<=0, go to R_DATA. rvalid=1 the next cycle (1-cycle latency).
  - R_DATA: rdata=registered mem[addr[ADDR_BITS+1:2]]; rid=captured id; rlast=(beat==len).
  - Beat advances on rvalid&rready: INCR addr+=4; FIXED addr held; beat++; rdata reloaded for the next beat (back-to-back beats, no bubble).
  - Last beat accepted: rvalid<=0, arready<=1, go to R_IDLE.
  - rvalid/rdata/rresp/rlast stay stable while rready=0.
- Response codes, per beat:
  - Decode miss (addr[31:ADDR_BITS+2] != BASE_ADDR field): DECERR 2'b11, rdata=0.
  - WRAP burst or arsize!=2: SLVERR 2'b10. Data still returned with INCR addressing.
  - Otherwise OKAY.
- INCR crossing the top of the window: later beats decode independently and may return DECERR.
- Write FSM W_RST -> W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1, wready=0. W data arriving before the AW handshake waits.
  - AW handshake: capture fields, awready<=0, wready<=1, go to W_DATA.
  - W_DATA: each wvalid&wready beat writes bytes where wstrb[i]=1 to mem[idx] at that clk edge. The address advances as for reads.
  - Write is suppressed, and the error latched sticky, on any of:
    - decode miss: DECERR
    - wid!=awid: SLVERR
    - WRAP burst or bad size: SLVERR
    - beat>len: SLVERR
  - Beat with wlast=1: wready<=0, bvalid<=1, bid=awid. bresp = sticky error (DECERR > SLVERR > OKAY). wlast at beat<len is also SLVERR, and the burst terminates on wlast.
  - W_RESP: hold until bready. Then bvalid<=0, awready<=1, clear sticky error, go to W_IDLE.
- Read and write FSMs run concurrently.
- Same-cycle read load and write to the same word: read returns the old data (write-first is not required); the following beat sees the new data.
- Reset mid-burst: both FSMs abort immediately and all valids drop. No B response is issued for the aborted write.

Test Plan:
- Reset release: arready/awready=0 during reset, =1 one cycle after resetn rises; rvalid=bvalid=0.
- Single write then read: AW 0x1c00_0010 len0, W 0xDEADBEEF strb 4'hF wlast -> bvalid, bresp 0, bid=awid. AR same address, id 4'h3 -> rdata 0xDEADBEEF, rid 3, rlast 1, rresp 0, one cycle after AR handshake.
- Byte strobes and INCR 4-beat: write 0x11223344 to words 0..3, then rewrite word1 with strb 4'b0010 data 0x0000AA00. Read len3 -> 0x11223344, 0x1122AA44, 0x11223344, 0x11223344; rlast only on beat 3. rready toggled every other cycle -> outputs held stable.
- Error paths: read 0x2000_0000 -> rresp 2'b11, rdata 0. Write with wid!=awid -> bresp 2'b10, memory unchanged. wlast at beat 1 of len3 -> bresp 2'b10.
- Concurrency and backpressure: AW+W same cycle as the CPU BIU issues them -> write completes. Hold bready=0 for 5 cycles -> bvalid stays 1 and awready stays 0; a concurrent read completes meanwhile.
- Reset asserted mid-4-beat read after beat 1 -> rvalid 0 immediately; after release a new read works.

Source files
------------

// File: rtl/axi_sram_slv.sv
// AXI3 slave terminating the CPU's external master port on an on-chip
// word-addressed SRAM. Read and write paths are independent single-outstanding
// FSMs supporting FIXED/INCR bursts up to 16 beats.
module axi_sram_slv #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int TAG_LO = ADDR_BITS + 2;

    localparam logic [1:0] R_RST  = 2'd0;
    localparam logic [1:0] R_IDLE = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_RST  = 2'd0;
    localparam logic [1:0] W_IDLE = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0] mem [DEPTH];

    function automatic logic addr_hit(input logic [31:0] a);
        return a[31:TAG_LO] == BASE_ADDR[31:TAG_LO];
    endfunction

    // Response codes are ordered by severity numerically (OKAY < SLVERR < DECERR).
    function automatic logic [1:0] sev_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Protection/lock/cache attributes carry no meaning for a plain SRAM.
    logic unused_attr;
    assign unused_attr = ^{arlock, arcache, arprot, awlock, awcache, awprot};

    // ---------------- read path ----------------
    logic [1:0]  r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [31:0] raddr_q, raddr_d;
    logic [3:0]  rlen_q, rlen_d;
    logic [3:0]  rbeat_q, rbeat_d;
    logic        rfixed_q, rfixed_d;
    logic        rbad_q, rbad_d;
    logic        r_load;
    logic [31:0] r_load_addr;
    logic        r_load_bad;

    // Read FSM next state; rdata/rresp are loaded for the beat being presented,
    // either from the AR handshake or from the beat that follows an accepted one.
    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rbeat_d     = rbeat_q;
        rfixed_d    = rfixed_q;
        rbad_d      = rbad_q;
        r_load      = 1'b0;
        r_load_addr = raddr_q;
        r_load_bad  = rbad_q;
        case (r_state_q)
            R_RST: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
            end
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rid_d       = arid;
                    raddr_d     = araddr;
                    rlen_d      = arlen;
                    rbeat_d     = '0;
                    rfixed_d    = (arburst == 2'b00);
                    rbad_d      = arburst[1] || (arsize != 3'b010);
                    r_load      = 1'b1;
                    r_load_addr = araddr;
                    r_load_bad  = rbad_d;
                    rlast_d     = (arlen == 4'd0);
                    rvalid_d    = 1'b1;
                    arready_d   = 1'b0;
                    r_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rbeat_d     = rbeat_q + 4'd1;
                        raddr_d     = rfixed_q ? raddr_q : raddr_q + 32'd4;
                        r_load      = 1'b1;
                        r_load_addr = raddr_d;
                        rlast_d     = (rbeat_d == rlen_q);
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
            end
        endcase
        if (r_load) begin
            if (!addr_hit(r_load_addr)) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = r_load_bad ? RESP_SLVERR : RESP_OKAY;
                rdata_d = mem[r_load_addr[ADDR_BITS+1:2]];
            end
        end
    end

    // Read-path registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_RST;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rfixed_q  <= 1'b0;
            rbad_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rfixed_q  <= rfixed_d;
            rbad_q    <= rbad_d;
        end
    end

    // ---------------- write path ----------------
    logic [1:0]  w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d;
    logic [4:0]  wbeat_q, wbeat_d;
    logic        wfixed_q, wfixed_d;
    logic        wbad_q, wbad_d;
    logic [1:0]  werr_q, werr_d;
    logic [1:0]  w_beat_err;
    logic [1:0]  w_err_acc;
    logic        mem_we;

    // Write FSM next state; each beat's error both gates the SRAM write and is
    // folded into the sticky response returned on B.
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wfixed_d   = wfixed_q;
        wbad_d     = wbad_q;
        werr_d     = werr_q;
        w_beat_err = RESP_OKAY;
        w_err_acc  = werr_q;
        mem_we     = 1'b0;
        case (w_state_q)
            W_RST: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
            end
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    bid_d     = awid;
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wbeat_d   = '0;
                    wfixed_d  = (awburst == 2'b00);
                    wbad_d    = awburst[1] || (awsize != 3'b010);
                    werr_d    = RESP_OKAY;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    if (!addr_hit(waddr_q)) begin
                        w_beat_err = RESP_DECERR;
                    end else if ((wid != bid_q) || wbad_q || (wbeat_q > {1'b0, wlen_q})) begin
                        w_beat_err = RESP_SLVERR;
                    end
                    mem_we    = (w_beat_err == RESP_OKAY);
                    w_err_acc = sev_max(werr_q, w_beat_err);
                    if (wlast && (wbeat_q < {1'b0, wlen_q})) begin
                        w_err_acc = sev_max(w_err_acc, RESP_SLVERR);
                    end
                    werr_d  = w_err_acc;
                    waddr_d = wfixed_q ? waddr_q : waddr_q + 32'd4;
                    wbeat_d = (wbeat_q == 5'd31) ? wbeat_q : wbeat_q + 5'd1;
                    if (wlast) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_err_acc;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    werr_d    = RESP_OKAY;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
            end
        endcase
    end

    // Write-path registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_RST;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wfixed_q  <= 1'b0;
            wbad_q    <= 1'b0;
            werr_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wfixed_q  <= wfixed_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
        end
    end

    // SRAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr_q[ADDR_BITS+1:2]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule
